demux_route_scheduler: RTL and testbench
========================================

Name: demux_route_scheduler

Overview:
Sequences a shared 1x8 demultiplexer that distributes single words from one upstream source to eight downstream lanes.
- Accepts a word plus a 3-bit destination over a valid/ready handshake.
- Drives the demux select and holds the word until the selected lane accepts it.
- Drops words aimed at disabled lanes, or at lanes that stall past a timeout, and counts the drops.
- Sits between the upstream word source and the eight lane consumers.

Parameters:
DATA_W, 8, width of the routed data word
TIMEOUT_CYC, 16, maximum SEND cycles waiting for out_ready before the word is dropped (minimum 1)
CNT_W, 8, width of the saturating drop counter

Ports:
clk  input  1  single clock; all state changes on the rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream word valid
in_ready  output  1  scheduler can accept a word (high only in IDLE)
in_data  input  DATA_W  upstream word
in_dest  input  3  destination lane index 0..7
lane_en  input  8  per-lane enable mask, sampled only at acceptance
out_valid  output  8  one-hot lane valid (all zero when not in SEND)
out_data  output  DATA_W  captured word, shared by all lanes
out_ready  input  8  per-lane ready from the consumers
sel  output  3  current demux select (captured in_dest)
busy  output  1  high in SEND or DROP
drop_pulse  output  1  one-cycle pulse per dropped word
drop_cnt  output  CNT_W  saturating count of dropped words

Behaviour:
- Reset (asynchronous, takes effect immediately on rst_n low):
  - state = IDLE, timer = 0.
  - Outputs: out_valid = 0, out_data = 0, sel = 0, busy = 0, drop_pulse = 0, drop_cnt = 0.
  - in_ready = 1 once rst_n is high.
- States: IDLE, SEND, DROP.
- IDLE:
  - in_ready = 1 (combinational from state).
  - On in_valid = 1, the word is accepted: register in_data -> out_data and in_dest -> sel; clear the timer.
  - lane_en[in_dest] = 1 -> SEND; otherwise -> DROP.
- SEND:
  - in_ready = 0; out_valid = one-hot of sel, derived through the demux sub-module.
  - out_ready[sel] = 1: the transfer completes and the next state is IDLE.
  - Otherwise the timer increments. If the timer equals TIMEOUT_CYC-1, the next state is DROP.
  - out_ready on any non-selected lane is ignored.
- DROP:
  - Lasts exactly one cycle: drop_pulse = 1, out_valid = 0.
  - drop_cnt increments by 1, saturating at 2^CNT_W-1 (no wrap).
  - Next state is IDLE.
- Latency and throughput:
  - Word accepted at edge T; out_valid is high in cycle T+1.
  - If out_ready[sel] is high in T+1: out_valid drops and in_ready rises at T+2.
  - Peak throughput is one word per 2 cycles.
- Holding rules:
  - out_data and sel hold their values through SEND and DROP.
  - They retain the last word in IDLE and are not cleared.
  - out_data must not change while out_valid is high.
- Boundary conditions:
  - out_ready[sel] rising in the same cycle the timer reaches TIMEOUT_CYC-1: the transfer wins, there is no drop, and drop_cnt is unchanged.
  - lane_en changes during SEND have no effect on the word in flight.
  - in_valid during SEND or DROP is not accepted (in_ready = 0); upstream must hold the word.
  - Reset mid-SEND: out_valid goes low immediately, the in-flight word is lost and not counted, and drop_cnt is cleared.
  - TIMEOUT_CYC = 1: a lane not ready in the first SEND cycle causes a drop.
- busy = (state != IDLE).

Decomposition:
- Shared package drs_pkg holds:
  - state enum (IDLE, SEND, DROP);
  - LANES = 8 and SEL_W = 3 constants;
  - saturating-increment function for the counter.
- Sub-module demux_1x8_onehot: a combinational 1-to-8 demux.
  - Inputs: enable (state == SEND) and sel[2:0].
  - Output: out_valid[7:0].
  - Instantiated once.
- Timer and FSM stay in the top module.

Test Plan:
- Reset then basic route: lane_en = 8'hFF, in_data = 8'hA5, in_dest = 3'd5, out_ready = 8'h20 -> out_valid = 8'b0010_0000 the cycle after acceptance, out_data = 8'hA5, sel = 5, back in IDLE the next cycle, drop_cnt = 0.
- Disabled lane: lane_en = 8'hFD, in_dest = 3'd1 -> one DROP cycle, drop_pulse = 1 for 1 cycle, out_valid stays 0, drop_cnt = 1.
- Timeout: TIMEOUT_CYC = 16, in_dest = 3'd3, out_ready = 0 -> out_valid = 8'h08 for exactly 16 cycles, then DROP, drop_cnt increments by 1.
- Timeout race: out_ready[3] asserted exactly in the 16th SEND cycle -> transfer completes, no drop_pulse; out_ready[6] asserted instead -> ignored and the word is dropped.
- Back-to-back with stalls:
  - Stimulus: five words to dest 1, 5, 3, 7, 2 with in_valid held high; each out_ready asserted after 2 cycles.
  - Response: in_ready low during each SEND; every word is delivered in order to the correct one-hot lane and none are lost.
- Async reset mid-SEND: rst_n pulled low between clock edges while out_valid = 8'h80 -> out_valid = 0, drop_cnt = 0 immediately; after release, in_ready = 1 and the next word routes normally.
- Counter saturation, with CNT_W = 2: five disabled-lane drops -> drop_cnt reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/drs_pkg.sv
// Shared types, constants and helpers for the demux route scheduler.
package drs_pkg;

    localparam int LANES = 8;
    localparam int SEL_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DROP = 2'd2
    } state_t;

    // Increment that sticks at max_val instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
        if (val >= max_val) begin
            return max_val;
        end
        return val + 32'd1;
    endfunction

endpackage

// File: rtl/demux_route_scheduler_demux.sv
// Combinational 1-to-8 one-hot demux for the lane valid strobes.
module demux_1x8_onehot
    import drs_pkg::*;
(
    input  logic             enable,
    input  logic [SEL_W-1:0] sel,
    output logic [LANES-1:0] out_valid
);

    // Raise exactly one lane valid while enabled, none otherwise.
    always_comb begin
        out_valid = '0;
        if (enable) begin
            out_valid[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/demux_route_scheduler.sv
// Scheduler for a shared 1x8 demux: accepts a word and destination, holds it
// until the chosen lane takes it, and drops it if the lane is disabled or
// stalls too long. Dropped words are counted in a saturating counter.
module demux_route_scheduler
    import drs_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [SEL_W-1:0]  in_dest,
    input  logic [LANES-1:0]  lane_en,
    output logic [LANES-1:0]  out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic [LANES-1:0]  out_ready,
    output logic [SEL_W-1:0]  sel,
    output logic              busy,
    output logic              drop_pulse,
    output logic [CNT_W-1:0]  drop_cnt
);

    // Timer must hold TIMEOUT_CYC-1; one spare bit keeps TIMEOUT_CYC = 1 legal.
    localparam int             TW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0]  TMR_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [31:0]    CNT_MAX  = (32'd1 << CNT_W) - 32'd1;

    state_t        state;
    logic [TW-1:0] timer;

    assign in_ready   = (state == IDLE);
    assign busy       = (state != IDLE);
    assign drop_pulse = (state == DROP);

    demux_1x8_onehot u_demux (
        .enable    (state == SEND),
        .sel       (sel),
        .out_valid (out_valid)
    );

    // Control FSM: capture on accept, wait for the selected lane, drop on timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            timer    <= '0;
            out_data <= '0;
            sel      <= '0;
            drop_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        out_data <= in_data;
                        sel      <= in_dest;
                        timer    <= '0;
                        // Enable mask is only consulted here; later changes
                        // cannot affect the word already in flight.
                        state    <= lane_en[in_dest] ? SEND : DROP;
                    end
                end
                SEND: begin
                    // A ready on the final timer cycle still completes the transfer.
                    if (out_ready[sel]) begin
                        state <= IDLE;
                    end else begin
                        timer <= timer + TW'(1);
                        if (timer == TMR_LAST) begin
                            state <= DROP;
                        end
                    end
                end
                DROP: begin
                    drop_cnt <= CNT_W'(sat_inc(32'(drop_cnt), CNT_MAX));
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_demux_route_scheduler.sv
// Directed self-checking bench for demux_route_scheduler.
module tb_demux_route_scheduler;

    logic       clk;
    logic       rst_n;

    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [2:0] in_dest;
    logic [7:0] lane_en;
    logic [7:0] out_valid;
    logic [7:0] out_data;
    logic [7:0] out_ready;
    logic [2:0] sel;
    logic       busy;
    logic       drop_pulse;
    logic [7:0] drop_cnt;

    logic       s_in_valid;
    logic       s_in_ready;
    logic [7:0] s_in_data;
    logic [2:0] s_in_dest;
    logic [7:0] s_lane_en;
    logic [7:0] s_out_valid;
    logic [7:0] s_out_data;
    logic [7:0] s_out_ready;
    logic [2:0] s_sel;
    logic       s_busy;
    logic       s_drop_pulse;
    logic [1:0] s_drop_cnt;

    int n_chk;
    int n_fail;

    demux_route_scheduler #(.DATA_W(8), .TIMEOUT_CYC(16), .CNT_W(8)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_dest    (in_dest),
        .lane_en    (lane_en),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .sel        (sel),
        .busy       (busy),
        .drop_pulse (drop_pulse),
        .drop_cnt   (drop_cnt)
    );

    demux_route_scheduler #(.DATA_W(8), .TIMEOUT_CYC(1), .CNT_W(2)) u_sat (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (s_in_valid),
        .in_ready   (s_in_ready),
        .in_data    (s_in_data),
        .in_dest    (s_in_dest),
        .lane_en    (s_lane_en),
        .out_valid  (s_out_valid),
        .out_data   (s_out_data),
        .out_ready  (s_out_ready),
        .sel        (s_sel),
        .busy       (s_busy),
        .drop_pulse (s_drop_pulse),
        .drop_cnt   (s_drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [2:0] b2b_dest [5];
    logic [7:0] b2b_data [5];
    logic [1:0] sat_exp  [5];

    initial begin
        n_chk  = 0;
        n_fail = 0;
        b2b_dest = '{3'd1, 3'd5, 3'd3, 3'd7, 3'd2};
        b2b_data = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        sat_exp  = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        rst_n = 1'b0;
        in_valid = 1'b0; in_data = '0; in_dest = '0; lane_en = '0; out_ready = '0;
        s_in_valid = 1'b0; s_in_data = '0; s_in_dest = '0; s_lane_en = '0; s_out_ready = '0;

        // Reset state
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'h0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_sel", 32'(sel), 32'h0);
        chk("rst_drop_pulse", 32'(drop_pulse), 32'h0);
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'h1);

        // Basic route to lane 5
        lane_en = 8'hFF; in_valid = 1'b1; in_data = 8'hA5; in_dest = 3'd5; out_ready = 8'h20;
        tick();
        in_valid = 1'b0;
        chk("basic_out_valid", 32'(out_valid), 32'h20);
        chk("basic_out_data", 32'(out_data), 32'hA5);
        chk("basic_sel", 32'(sel), 32'd5);
        chk("basic_in_ready", 32'(in_ready), 32'h0);
        chk("basic_busy", 32'(busy), 32'h1);
        tick();
        out_ready = 8'h00;
        chk("basic_idle_valid", 32'(out_valid), 32'h0);
        chk("basic_idle_ready", 32'(in_ready), 32'h1);
        chk("basic_drop_cnt", 32'(drop_cnt), 32'h0);
        chk("basic_data_hold", 32'(out_data), 32'hA5);

        // Disabled lane is dropped
        lane_en = 8'hFD; in_valid = 1'b1; in_data = 8'h3C; in_dest = 3'd1;
        tick();
        in_valid = 1'b0;
        chk("dis_drop_pulse", 32'(drop_pulse), 32'h1);
        chk("dis_out_valid", 32'(out_valid), 32'h0);
        chk("dis_busy", 32'(busy), 32'h1);
        tick();
        chk("dis_pulse_end", 32'(drop_pulse), 32'h0);
        chk("dis_drop_cnt", 32'(drop_cnt), 32'h1);
        chk("dis_in_ready", 32'(in_ready), 32'h1);

        // Timeout on lane 3: valid for exactly 16 cycles, then one DROP cycle
        lane_en = 8'hFF; in_valid = 1'b1; in_data = 8'h77; in_dest = 3'd3;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("tmo_valid_%0d", i), 32'(out_valid), 32'h08);
            tick();
        end
        chk("tmo_drop_pulse", 32'(drop_pulse), 32'h1);
        chk("tmo_out_valid", 32'(out_valid), 32'h0);
        tick();
        chk("tmo_drop_cnt", 32'(drop_cnt), 32'h2);

        // Ready on lane 3 in the 16th SEND cycle wins; lane_en change ignored
        in_valid = 1'b1; in_data = 8'h66; in_dest = 3'd3;
        tick();
        in_valid = 1'b0; lane_en = 8'h00;
        for (int i = 0; i < 15; i++) tick();
        chk("race_valid_last", 32'(out_valid), 32'h08);
        out_ready = 8'h08;
        tick();
        out_ready = 8'h00; lane_en = 8'hFF;
        chk("race_no_pulse", 32'(drop_pulse), 32'h0);
        chk("race_in_ready", 32'(in_ready), 32'h1);
        chk("race_drop_cnt", 32'(drop_cnt), 32'h2);

        // Ready on a non-selected lane in the 16th cycle is ignored
        in_valid = 1'b1; in_data = 8'h61; in_dest = 3'd3;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        out_ready = 8'h40;
        tick();
        out_ready = 8'h00;
        chk("race6_pulse", 32'(drop_pulse), 32'h1);
        tick();
        chk("race6_drop_cnt", 32'(drop_cnt), 32'h3);

        // Back-to-back words with in_valid held and 2-cycle stalls
        in_valid = 1'b1; in_data = b2b_data[0]; in_dest = b2b_dest[0];
        for (int k = 0; k < 5; k++) begin
            tick();
            if (k < 4) begin
                in_data = b2b_data[k+1]; in_dest = b2b_dest[k+1];
            end else begin
                in_valid = 1'b0;
            end
            chk($sformatf("b2b%0d_valid", k), 32'(out_valid), 32'(8'h01 << b2b_dest[k]));
            chk($sformatf("b2b%0d_data", k), 32'(out_data), 32'(b2b_data[k]));
            chk($sformatf("b2b%0d_in_ready", k), 32'(in_ready), 32'h0);
            tick();
            tick();
            chk($sformatf("b2b%0d_hold", k), 32'(out_data), 32'(b2b_data[k]));
            out_ready = 8'h01 << b2b_dest[k];
            tick();
            out_ready = 8'h00;
            chk($sformatf("b2b%0d_done", k), 32'(in_ready), 32'h1);
            chk($sformatf("b2b%0d_idle", k), 32'(out_valid), 32'h0);
        end
        chk("b2b_drop_cnt", 32'(drop_cnt), 32'h3);

        // Asynchronous reset while lane 7 is being offered
        in_valid = 1'b1; in_data = 8'h99; in_dest = 3'd7;
        tick();
        in_valid = 1'b0;
        chk("arst_pre_valid", 32'(out_valid), 32'h80);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'h0);
        chk("arst_drop_cnt", 32'(drop_cnt), 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        #1;
        rst_n = 1'b1;
        tick();
        chk("arst_in_ready", 32'(in_ready), 32'h1);
        in_valid = 1'b1; in_data = 8'h5A; in_dest = 3'd0; out_ready = 8'h01;
        tick();
        in_valid = 1'b0;
        chk("arst_route_valid", 32'(out_valid), 32'h01);
        chk("arst_route_data", 32'(out_data), 32'h5A);
        tick();
        out_ready = 8'h00;
        chk("arst_route_done", 32'(in_ready), 32'h1);
        chk("arst_route_cnt", 32'(drop_cnt), 32'h0);

        // Saturating counter (2 bits) via disabled-lane drops
        s_lane_en = 8'h00;
        for (int k = 0; k < 5; k++) begin
            s_in_valid = 1'b1; s_in_data = 8'(k); s_in_dest = 3'd4;
            tick();
            s_in_valid = 1'b0;
            chk($sformatf("sat%0d_pulse", k), 32'(s_drop_pulse), 32'h1);
            tick();
            chk($sformatf("sat%0d_cnt", k), 32'(s_drop_cnt), 32'(sat_exp[k]));
        end

        // Timeout of one cycle: lane not ready in the first SEND cycle drops
        s_lane_en = 8'hFF; s_in_valid = 1'b1; s_in_data = 8'hC3; s_in_dest = 3'd2;
        tick();
        s_in_valid = 1'b0;
        chk("t1_out_valid", 32'(s_out_valid), 32'h04);
        tick();
        chk("t1_drop_pulse", 32'(s_drop_pulse), 32'h1);
        chk("t1_out_valid_drop", 32'(s_out_valid), 32'h0);
        tick();
        chk("t1_in_ready", 32'(s_in_ready), 32'h1);
        chk("t1_cnt_sat", 32'(s_drop_cnt), 32'h3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
